// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle for the i-cache refill controller.
//
// Carries both sides of the controller:
//   cache side  : req_valid/req_ready/req_addr, resp_valid/resp_addr/resp_data, flush
//   memory side : mem_read/mem_address (out), mem_readdata/mem_busywait (in)
//
// Modports:
//   master : the refill controller. It serves the cache and initiates every
//            memory read.
//   slave  : the environment, that is, the cache plus the instruction memory.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
);
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               resp_valid;
  logic [ADDR_W-1:0]  resp_addr;
  logic [BLOCK_W-1:0] resp_data;
  logic               flush;
  logic               mem_read;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport master (
    input  req_valid, req_addr, flush, mem_readdata, mem_busywait,
    output req_ready, resp_valid, resp_addr, resp_data, mem_read, mem_address
  );

  modport slave (
    output req_valid, req_addr, flush, mem_readdata, mem_busywait,
    input  req_ready, resp_valid, resp_addr, resp_data, mem_read, mem_address
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache refill controller with a one-entry next-block stream buffer.
//
// The controller accepts one block request at a time. A hit in the stream
// buffer is answered in one cycle. A miss drives the byte-serial memory
// handshake (read/address/busywait) and returns the captured 128-bit block.
// After each response it can prefetch the next sequential block into the
// buffer. Asserting flush invalidates the buffer.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low reset
//   bus       : cache request/response, flush and memory handshake (master side)
//   hit_count : saturating 16-bit count of stream-buffer hits
module icache_refill_ctrl #(
  parameter int ADDR_W      = 28,
  parameter int BLOCK_W     = 128,
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  icache_refill_ctrl_if.master bus,
  output logic [15:0]          hit_count
);

  typedef enum logic [2:0] {IDLE, DEMAND, DCAP, RESP, PREFETCH, PCAP} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
  logic [ADDR_W-1:0]  resp_addr_q, resp_addr_d;
  logic [BLOCK_W-1:0] resp_data_q, resp_data_d;
  logic [ADDR_W-1:0]  pf_addr_q, pf_addr_d;
  logic [BLOCK_W-1:0] pf_data_q, pf_data_d;
  logic               pf_valid_q, pf_valid_d;
  logic               stale_q, stale_d;
  logic [15:0]        hit_count_q, hit_count_d;
  logic               accept;
  logic               hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_addr   = resp_addr_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.mem_read    = (state_q == DEMAND) || (state_q == PREFETCH);
  assign bus.mem_address = mem_address_q;
  assign hit_count       = hit_count_q;

  assign accept = bus.req_valid && (state_q == IDLE);
  // A flush in the same cycle as the request wins, so that request is a miss.
  assign hit    = pf_valid_q && (pf_addr_q == bus.req_addr) && !bus.flush;

  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    resp_addr_d   = resp_addr_q;
    resp_data_d   = resp_data_q;
    pf_addr_d     = pf_addr_q;
    pf_data_d     = pf_data_q;
    pf_valid_d    = pf_valid_q;
    stale_d       = stale_q;
    hit_count_d   = hit_count_q;

    if (bus.flush) pf_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        stale_d = 1'b0;
        if (accept) begin
          if (hit) begin
            resp_data_d = pf_data_q;
            resp_addr_d = pf_addr_q;
            pf_valid_d  = 1'b0;
            hit_count_d = sat_inc16(hit_count_q);
            state_d     = RESP;
          end else begin
            mem_address_d = bus.req_addr;
            state_d       = DEMAND;
          end
        end
      end
      DEMAND: begin
        if (!bus.mem_busywait) state_d = DCAP;
      end
      // The last byte lands on the edge where busywait is seen low, so the
      // block is complete only one cycle later.
      DCAP: begin
        resp_data_d = bus.mem_readdata;
        resp_addr_d = mem_address_q;
        state_d     = RESP;
      end
      RESP: begin
        if (PREFETCH_EN) begin
          mem_address_d = resp_addr_q + ADDR_W'(1);
          state_d       = PREFETCH;
        end else begin
          state_d = IDLE;
        end
      end
      // A started read cannot be aborted because the memory does not rewind.
      // A flush therefore only marks the result stale.
      PREFETCH: begin
        if (bus.flush) stale_d = 1'b1;
        if (!bus.mem_busywait) state_d = PCAP;
      end
      PCAP: begin
        if (!stale_q && !bus.flush) begin
          pf_data_d  = bus.mem_readdata;
          pf_addr_d  = mem_address_q;
          pf_valid_d = 1'b1;
        end
        // PCAP always enters IDLE, so the stale flag ends here.
        stale_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      resp_addr_q   <= '0;
      resp_data_q   <= '0;
      pf_addr_q     <= '0;
      pf_data_q     <= '0;
      pf_valid_q    <= 1'b0;
      stale_q       <= 1'b0;
      hit_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      resp_addr_q   <= resp_addr_d;
      resp_data_q   <= resp_data_d;
      pf_addr_q     <= pf_addr_d;
      pf_data_q     <= pf_data_d;
      pf_valid_q    <= pf_valid_d;
      stale_q       <= stale_d;
      hit_count_q   <= hit_count_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  icache_refill_ctrl_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();
  icache_refill_ctrl_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus_np ();
  logic [15:0] hit_count, hit_count_np;

  icache_refill_ctrl #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .PREFETCH_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .bus(bus), .hit_count(hit_count));
  icache_refill_ctrl #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .PREFETCH_EN(1'b0)) dut_np (
    .clock(clock), .reset(reset), .bus(bus_np), .hit_count(hit_count_np));

  // Memory contents: byte i of the flat byte space holds i mod 256.
  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a, input int j);
    return {a[3:0], 4'(j)};
  endfunction

  function automatic logic [BLOCK_W-1:0] blk(input logic [ADDR_W-1:0] a);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[j*8 +: 8] = mem_byte(a, j);
    return r;
  endfunction

  // Byte-serial memory models: one byte per cycle while read is high.
  // busywait is low in the 16th cycle, and the last byte lands on that edge.
  logic [3:0]         cnt, cnt_np;
  logic [BLOCK_W-1:0] rd, rd_np;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0; rd <= '0;
    end else if (bus.mem_read) begin
      rd[{cnt, 3'b000} +: 8] <= mem_byte(bus.mem_address, int'(cnt));
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end
  assign bus.mem_busywait = bus.mem_read && (cnt != 4'd15);
  assign bus.mem_readdata = rd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_np <= '0; rd_np <= '0;
    end else if (bus_np.mem_read) begin
      rd_np[{cnt_np, 3'b000} +: 8] <= mem_byte(bus_np.mem_address, int'(cnt_np));
      cnt_np <= cnt_np + 4'd1;
    end else begin
      cnt_np <= '0;
    end
  end
  assign bus_np.mem_busywait = bus_np.mem_read && (cnt_np != 4'd15);
  assign bus_np.mem_readdata = rd_np;

  // Address stability monitor: while read is high, and in the cycle after it falls.
  logic              prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int                viol = 0;
  always @(negedge clock) begin
    if (!reset) begin
      prev_rd <= 1'b0;
    end else begin
      if (prev_rd && bus.mem_address !== prev_addr) viol <= viol + 1;
      prev_rd   <= bus.mem_read;
      prev_addr <= bus.mem_address;
    end
  end

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] data;
    int                 lat;
    int                 rd_cycles;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] exp_hits = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Request on the prefetching instance. The expectation is queued at drive
  // time and popped when the response appears.
  task automatic do_req(input logic [ADDR_W-1:0] a, input bit exp_hit,
                        input bit with_flush, input string tag);
    exp_t e;
    int   w, lat, rdc;
    bit   got;
    w = 0;
    while (!bus.req_ready && w < 60) begin @(negedge clock); w++; end
    if (!bus.req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_ready: req_ready=%0b required 1", tag, bus.req_ready);
      return;
    end
    e.addr = a; e.data = blk(a);
    e.lat = exp_hit ? 1 : 18; e.rd_cycles = exp_hit ? 0 : 16;
    if (exp_hit) exp_hits = exp_hits + 16'd1;
    sb.push_back(e);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.flush = with_flush;
    @(posedge clock); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    lat = 0; rdc = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clock); lat++;
      if (bus.mem_read) rdc++;
      if (bus.resp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL %s_timeout: no resp_valid after %0d cycles, required at %0d", tag, lat, e.lat);
      return;
    end
    n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL %s_latency: %0d required %0d", tag, lat, e.lat); end
    n_cmp++; if (rdc !== e.rd_cycles) begin n_bad++; $display("FAIL %s_read_cycles: %0d required %0d", tag, rdc, e.rd_cycles); end
    n_cmp++; if (bus.resp_addr !== e.addr) begin n_bad++; $display("FAIL %s_resp_addr: %h required %h", tag, bus.resp_addr, e.addr); end
    n_cmp++; if (bus.resp_data !== e.data) begin n_bad++; $display("FAIL %s_resp_data: %h required %h", tag, bus.resp_data, e.data); end
    n_cmp++; if (hit_count !== exp_hits) begin n_bad++; $display("FAIL %s_hit_count: %0d required %0d", tag, hit_count, exp_hits); end
    @(negedge clock);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL %s_resp_pulse: resp_valid=%0b required 0", tag, bus.resp_valid); end
    n_cmp++; if (bus.resp_addr !== e.addr) begin n_bad++; $display("FAIL %s_resp_hold: %h required %h", tag, bus.resp_addr, e.addr); end
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0;
    bus_np.req_valid = 1'b0; bus_np.req_addr = '0; bus_np.flush = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: %0b required 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: %0b required 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_addr !== '0) begin n_bad++; $display("FAIL rst_resp_addr: %h required 0", bus.resp_addr); end
    n_cmp++; if (bus.resp_data !== '0) begin n_bad++; $display("FAIL rst_resp_data: %h required 0", bus.resp_data); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mem_read: %0b required 0", bus.mem_read); end
    n_cmp++; if (bus.mem_address !== '0) begin n_bad++; $display("FAIL rst_mem_address: %h required 0", bus.mem_address); end
    n_cmp++; if (hit_count !== 16'd0) begin n_bad++; $display("FAIL rst_hit_count: %0d required 0", hit_count); end
    // Reset in the fifth DEMAND cycle.
    bus.req_valid = 1'b1; bus.req_addr = 28'h0000123;
    @(posedge clock); #1 bus.req_valid = 1'b0;
    repeat (5) @(negedge clock);
    n_cmp++; if (bus.mem_read !== 1'b1) begin n_bad++; $display("FAIL rst_mid_read_before: %0b required 1", bus.mem_read); end
    n_cmp++; if (bus.mem_address !== 28'h0000123) begin n_bad++; $display("FAIL rst_mid_addr_before: %h required 0000123", bus.mem_address); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_async_mem_read: %0b required 0", bus.mem_read); end
    n_cmp++; if (bus.mem_address !== '0) begin n_bad++; $display("FAIL rst_async_mem_address: %h required 0", bus.mem_address); end
    @(negedge clock); #1 reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: %0b required 1", bus.req_ready); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_release_read: %0b required 0", bus.mem_read); end
  endtask

  task automatic test_cold_miss_np;
    logic [BLOCK_W-1:0] exp_blk;
    int lat, rdc;
    bit got;
    exp_blk = 128'h0F0E0D0C0B0A09080706050403020100;
    bus_np.req_valid = 1'b1; bus_np.req_addr = '0;
    @(posedge clock); #1 bus_np.req_valid = 1'b0;
    lat = 0; rdc = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clock); lat++;
      if (bus_np.mem_read) rdc++;
      if (bus_np.resp_valid) got = 1'b1;
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL cold_timeout: no resp_valid in %0d cycles", lat); end
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL cold_latency: %0d required 18", lat); end
    n_cmp++; if (rdc !== 16) begin n_bad++; $display("FAIL cold_read_cycles: %0d required 16", rdc); end
    n_cmp++; if (bus_np.resp_data !== exp_blk) begin n_bad++; $display("FAIL cold_data: %h required %h", bus_np.resp_data, exp_blk); end
    n_cmp++; if (bus_np.resp_addr !== '0) begin n_bad++; $display("FAIL cold_addr: %h required 0", bus_np.resp_addr); end
    @(negedge clock);
    n_cmp++; if (bus_np.req_ready !== 1'b1) begin n_bad++; $display("FAIL cold_no_prefetch_ready: %0b required 1", bus_np.req_ready); end
    n_cmp++; if (bus_np.mem_read !== 1'b0) begin n_bad++; $display("FAIL cold_no_prefetch_read: %0b required 0", bus_np.mem_read); end
    n_cmp++; if (hit_count_np !== 16'd0) begin n_bad++; $display("FAIL cold_hit_count: %0d required 0", hit_count_np); end
  endtask

  task automatic test_seq_hit;
    int k;
    do_req(28'd0, 1'b0, 1'b0, "seq_miss0");
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 28'd1) begin
      n_bad++; $display("FAIL seq_prefetch1: read=%0b addr=%h required read=1 addr=0000001", bus.mem_read, bus.mem_address); end
    k = 1;
    while (!bus.req_ready && k < 60) begin @(negedge clock); k++; end
    n_cmp++; if (k !== 18) begin n_bad++; $display("FAIL seq_ready_return: cycle N+%0d required N+18", k); end
    do_req(28'd1, 1'b1, 1'b0, "seq_hit1");
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 28'd2) begin
      n_bad++; $display("FAIL seq_prefetch2: read=%0b addr=%h required read=1 addr=0000002", bus.mem_read, bus.mem_address); end
  endtask

  task automatic test_nonseq_miss;
    do_req(28'd5, 1'b0, 1'b0, "nonseq_miss5");
    n_cmp++; if (bus.mem_address !== 28'd6) begin n_bad++; $display("FAIL nonseq_prefetch6: %h required 0000006", bus.mem_address); end
    do_req(28'd6, 1'b1, 1'b0, "nonseq_hit6");
  endtask

  task automatic test_flush;
    do_req(28'd10, 1'b0, 1'b0, "flush_miss10");
    // Still in PREFETCH of block 11.
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    do_req(28'd11, 1'b0, 1'b0, "flush_stale11");
    do_req(28'd12, 1'b0, 1'b1, "flush_with_req12");
  endtask

  task automatic test_wrap;
    do_req(28'hFFFFFFF, 1'b0, 1'b0, "wrap_miss");
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 28'd0) begin
      n_bad++; $display("FAIL wrap_prefetch: read=%0b addr=%h required read=1 addr=0000000", bus.mem_read, bus.mem_address); end
    do_req(28'd0, 1'b1, 1'b0, "wrap_hit0");
  endtask

  task automatic test_protocol;
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL addr_stability: %0d changes required 0", viol); end
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_cold_miss_np();
    test_seq_hit();
    test_nonseq_miss();
    test_flush();
    test_wrap();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Refill initiator between the i-cache miss path and the 16-cycle, byte-serial instruction memory. It accepts one block-read request at a time and drives the memory `read`/`address`/`busywait` handshake. It captures the 128-bit block and returns it to the cache. It can then prefetch the next sequential block into a one-entry stream buffer, so a following sequential miss is served in one cycle. A `flush` input invalidates the buffer on cache switches and context switches.

## Interface
- `ADDR_W`, 28: block address width; matches the memory `address` port.
- `BLOCK_W`, 128: block width in bits.
- `PREFETCH_EN`, 1: 1 enables next-block prefetch; 0 makes the block a plain demand refiller.
- `clock`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state.
- `req_valid`  input  1  cache requests a block.
- `req_addr`  input  ADDR_W  block address of the request.
- `req_ready`  output  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `resp_valid`  output  1  one-cycle pulse when the block is returned.
- `resp_addr`  output  ADDR_W  address of the returned block; held until the next response.
- `resp_data`  output  BLOCK_W  returned block; held until the next response.
- `flush`  input  1  invalidates the prefetch buffer.
- `mem_read`  output  1  memory read request.
- `mem_address`  output  ADDR_W  memory block address.
- `mem_readdata`  input  BLOCK_W  memory block data.
- `mem_busywait`  input  1  memory busy.
- `hit_count`  output  16  saturating count of prefetch-buffer hits.

## Operation
FSM states: IDLE, DEMAND, DCAP, RESP, PREFETCH, PCAP.

- **IDLE**
  - A request hits when `pf_valid && pf_addr == req_addr`. On an accepted hit: `resp_data`/`resp_addr` are loaded from the buffer, `pf_valid` is cleared, `hit_count` increments, next state is RESP.
  - On an accepted miss: `mem_address <= req_addr`, next state is DEMAND.
- **DEMAND**
  - `mem_read` is 1 and `mem_address` is held.
  - On an edge with `mem_busywait == 0`, `mem_read` drops to 0 and the FSM goes to DCAP.
- **DCAP**
  - `mem_read` is 0 and the address is held.
  - On the edge, `resp_data <= mem_readdata`, `resp_addr <= mem_address`, next state is RESP.
  - The capture is one cycle after `busywait` falls because the last byte lands on the falling-busywait edge.
- **RESP**
  - `resp_valid` is 1 for exactly one cycle.
  - If `PREFETCH_EN`: `mem_address <= resp_addr + 1` (mod 2^ADDR_W, so 0xFFFFFFF wraps to 0) and next state is PREFETCH. Otherwise next state is IDLE.
- **PREFETCH / PCAP**
  - Same handshake as DEMAND / DCAP.
  - PCAP loads `pf_data`, `pf_addr` and sets `pf_valid`, unless the prefetch has been marked stale. Next state is IDLE.
- **Prefetch cannot be aborted**: the memory counter does not rewind when `read` drops, so every started read runs to completion. Demand requests wait, because `req_ready` is 0 outside IDLE.
- **Flush**
  - `flush` clears `pf_valid` in any state.
  - If asserted in PREFETCH or PCAP, it sets a stale flag. PCAP then discards the data, and the flag clears on entry to IDLE.
- **Flush coinciding with a request in IDLE**: flush wins. The request is treated as a miss, and `hit_count` does not increment.
- **`hit_count`**: saturates at 0xFFFF.

## Timing
- **Reset values**: state IDLE, `mem_read` 0, `mem_address` 0, `resp_valid` 0, `resp_data` 0, `resp_addr` 0, `pf_valid` 0, stale flag 0, `hit_count` 0.
- **Reset mid-transfer**: the FSM returns to IDLE immediately and `mem_read` drops asynchronously. The memory is reset by the same system reset.
- **Miss latency**: with accept on edge E0, `mem_read` is high in cycles 1–16 and `busywait` is low in cycle 16. DCAP is cycle 17 and `resp_valid` is high in cycle 18.
- **Hit latency**: `resp_valid` is high in cycle 1 after the accept edge.
- **Prefetch after a response in cycle N**: PREFETCH occupies cycles N+1..N+16, PCAP is N+17, and `req_ready` returns to 1 in cycle N+18.
- `mem_address` is stable whenever `mem_read` is 1 and in the cycle after it falls.

## Test plan
- **Reset**: drive reset low mid-DEMAND (cycle 5) -> `mem_read` goes to 0 immediately; all outputs take their reset values; `req_ready` is 1 after release.
- **Cold miss**: `PREFETCH_EN=0`, memory byte i = i, request addr 0 -> `resp_valid` in cycle 18 with `resp_data` = 0x0F0E…0100; `mem_read` high for exactly 16 cycles.
- **Sequential hit**: request 0, then request 1 when `req_ready` rises -> second `resp_valid` one cycle after accept, data = bytes 16–31, `hit_count` = 1; a prefetch of addr 2 follows.
- **Non-sequential miss**: after buffering addr 1, request 5 -> full 18-cycle miss, `hit_count` unchanged, buffer now holds addr 6.
- **Flush**: flush during PREFETCH, then request the prefetched address -> treated as a miss, 18-cycle latency, `hit_count` unchanged; flush together with a hitting request in IDLE -> also a miss.
- **Address wrap**: request 0xFFFFFFF -> prefetch `mem_address` = 0x0000000; a following request 0 hits.
